// File: rtl/uart_tx_arbiter_if.sv
// Bundle between four byte requesters, the arbiter and a uart_tx.
//
// Handshakes:
//  - req[i] is a level request. A requester holds req[i] and its byte on
//    req_data[8i+7:8i] until it sees ack[i] for one clock. ack[i] marks the
//    byte as accepted; dropping req[i] afterwards does not cancel the frame.
//  - tx_dv is a one-clock start strobe to the transmitter, with tx_data
//    valid alongside it and held until the next grant.
//  - tx_done is a one-clock completion strobe from the transmitter. It is
//    only meaningful while a frame is outstanding.
//  - done[i] / err[i] are one-clock completion / timeout reports.
interface uart_tx_arbiter_if;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic [3:0]  ack;
  logic [3:0]  done;
  logic [3:0]  err;
  logic [7:0]  tx_data;
  logic        tx_dv;
  logic        tx_done;
  logic        busy;
  logic [1:0]  grant_id;

  // Requesters plus transmitter side.
  modport master (
    output req, req_data, tx_done,
    input  ack, done, err, tx_data, tx_dv, busy, grant_id
  );

  // Arbiter side.
  modport slave (
    input  req, req_data, tx_done,
    output ack, done, err, tx_data, tx_dv, busy, grant_id
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one uart_tx between four byte requesters.
// One frame is outstanding at a time: grant, strobe the transmitter, wait
// for tx_done (or give up after TIMEOUT_CYCLES), then hold the line idle for
// GAP_CYCLES before the next grant.
module uart_tx_arbiter #(
  parameter int GAP_CYCLES     = 2,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic                clk,
  input  logic                rst_n,
  uart_tx_arbiter_if.slave    bus,
  output logic [1:0]          state_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    WAIT = 2'd2,
    GAP  = 2'd3
  } state_e;

  // Counter widths always at least one bit, even for GAP_CYCLES = 0.
  localparam int TW = $clog2(TIMEOUT_CYCLES + 2);
  localparam int GW = $clog2(GAP_CYCLES + 2);

  // A frame ends in GAP, or straight in IDLE when no gap is requested.
  localparam state_e EXIT_STATE = (GAP_CYCLES == 0) ? IDLE : GAP;

  state_e        state_q, state_d;
  logic [7:0]    tx_data_q, tx_data_d;
  logic [1:0]    grant_q, grant_d;
  logic [1:0]    last_grant_q, last_grant_d;
  logic [TW-1:0] wait_cnt_q, wait_cnt_d;
  logic [GW-1:0] gap_cnt_q, gap_cnt_d;
  logic [3:0]    done_q, done_d;
  logic [3:0]    err_q, err_d;

  logic [1:0]    winner;
  logic          winner_found;
  logic [3:0]    grant_onehot;
  logic          wait_last;
  logic          gap_last;

  assign grant_onehot = 4'b0001 << grant_q;
  assign wait_last    = (32'(wait_cnt_q) == TIMEOUT_CYCLES - 1);
  assign gap_last     = (32'(gap_cnt_q) >= GAP_CYCLES - 1);

  // Round-robin pick: scan upward from the requester after the last grant.
  always_comb begin
    winner       = 2'd0;
    winner_found = 1'b0;
    for (int off = 0; off < 4; off++) begin
      logic [1:0] idx;
      idx = last_grant_q + 2'(off + 1);
      if (bus.req[idx] && !winner_found) begin
        winner       = idx;
        winner_found = 1'b1;
      end
    end
  end

  // Next-state and registered-output logic for the grant sequence.
  always_comb begin
    state_d      = state_q;
    tx_data_d    = tx_data_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    wait_cnt_d   = wait_cnt_q;
    gap_cnt_d    = gap_cnt_q;
    done_d       = 4'b0000;
    err_d        = 4'b0000;
    unique case (state_q)
      IDLE: begin
        // Requests are only looked at here; anything raised mid-frame waits.
        if (winner_found) begin
          tx_data_d    = bus.req_data[{winner, 3'b000} +: 8];
          grant_d      = winner;
          last_grant_d = winner;
          state_d      = SEND;
        end
      end
      SEND: begin
        wait_cnt_d = '0;
        state_d    = WAIT;
      end
      WAIT: begin
        // tx_done is checked first so a same-cycle timeout loses the tie.
        if (bus.tx_done) begin
          done_d    = grant_onehot;
          gap_cnt_d = '0;
          state_d   = EXIT_STATE;
        end else if (wait_last) begin
          err_d     = grant_onehot;
          gap_cnt_d = '0;
          state_d   = EXIT_STATE;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end
      GAP: begin
        if (gap_last) begin
          gap_cnt_d = '0;
          state_d   = IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset drops any frame in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      tx_data_q    <= 8'h00;
      grant_q      <= 2'd0;
      last_grant_q <= 2'd3;
      wait_cnt_q   <= '0;
      gap_cnt_q    <= '0;
      done_q       <= 4'b0000;
      err_q        <= 4'b0000;
    end else begin
      state_q      <= state_d;
      tx_data_q    <= tx_data_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      wait_cnt_q   <= wait_cnt_d;
      gap_cnt_q    <= gap_cnt_d;
      done_q       <= done_d;
      err_q        <= err_d;
    end
  end

  // Strobes decoded from state so tx_dv/ack can only appear in SEND.
  always_comb begin
    bus.tx_dv    = (state_q == SEND);
    bus.ack      = (state_q == SEND) ? grant_onehot : 4'b0000;
    bus.busy     = (state_q != IDLE);
    bus.done     = done_q;
    bus.err      = err_q;
    bus.tx_data  = tx_data_q;
    bus.grant_id = grant_q;
    state_o      = state_q;
  end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 The block SHALL have parameter GAP_CYCLES, default 2, idle clocks forced between the end of one frame and the next grant (0 allowed).
REQ-002 The block SHALL have parameter TIMEOUT_CYCLES, default 1000, the maximum number of clocks to wait for tx_done before abandoning a frame.
REQ-003 clk  input  1  system clock; the block is active on the rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 req  input  4  per-requester send request, held high until ack.
REQ-006 req_data  input  32  requester i byte on bits [8i+7:8i].
REQ-007 ack  output  4  one-clock pulse on bit i when requester i's byte is issued to the transmitter.
REQ-008 done  output  4  one-clock pulse on bit i when requester i's frame completes.
REQ-009 err  output  4  one-clock pulse on bit i when requester i's frame times out.
REQ-010 tx_data  output  8  byte to the uart_tx data_byte input.
REQ-011 tx_dv  output  1  one-clock start strobe to the uart_tx tx_dv input.
REQ-012 tx_done  input  1  frame-complete strobe from uart_tx.
REQ-013 busy  output  1  high in every state except IDLE.
REQ-014 grant_id  output  2  index of the current or last granted requester.

Function
REQ-015 The block SHALL implement the states IDLE, SEND, WAIT and GAP.
REQ-016 In IDLE with any req bit high, the block SHALL select a winner round-robin, starting at the index (last_grant+1) mod 4 and ascending with wrap.
REQ-017 On the selecting edge, the block SHALL register req_data[winner] into tx_data, load grant_id and last_grant with the winner, and enter SEND.
REQ-018 SEND SHALL last exactly one clock, asserting tx_dv=1 and ack[grant_id]=1, then enter WAIT.
REQ-019 Latency from req rising (sampled in IDLE) to tx_dv SHALL be 2 clocks.
REQ-020 tx_data SHALL hold stable from SEND until the next grant.
REQ-021 In WAIT, tx_done=1 SHALL pulse done[grant_id] on the following clock and enter GAP.
REQ-022 A wait counter SHALL clear on entering WAIT; when it reaches TIMEOUT_CYCLES without tx_done, the block SHALL pulse err[grant_id] and enter GAP.
REQ-023 If tx_done and the timeout occur in the same clock, tx_done SHALL win: done pulses and err does not.
REQ-024 GAP SHALL last GAP_CYCLES clocks, then return to IDLE; with GAP_CYCLES=0, the exit from WAIT SHALL go directly to IDLE.
REQ-025 tx_done asserted outside WAIT SHALL be ignored.
REQ-026 A requester dropping req after selection SHALL NOT abort the frame.
REQ-027 Requests arriving in any state other than IDLE SHALL be held off until IDLE.
REQ-028 At most one bit of ack, done and err SHALL be high in any clock; tx_dv SHALL never be high outside SEND.

Reset
REQ-029 While rst_n=0, the block SHALL immediately force state=IDLE and tx_dv=0, ack=done=err=0, tx_data=8'h00, busy=0, grant_id=0, last_grant=3, and all counters to 0.
REQ-030 Reset asserted mid-frame SHALL drop the frame silently, with no done or err pulse.
REQ-031 The first arbitration after reset SHALL favour requester 0.

Verification
REQ-032 Single request: req=4'b0100, req_data[23:16]=8'hA9 -> 2 clocks later tx_dv=1, tx_data=8'hA9, ack=4'b0100; a uart_rx looped back receives 8'hA9; done[2] pulses once.
REQ-033 Fairness: req=4'b1111 held with bytes 8'h10/8'h11/8'h12/8'h13 -> grant order 0,1,2,3,0 with exactly GAP_CYCLES idle clocks between each done and the next tx_dv.
REQ-034 Timeout: tx_done tied low with TIMEOUT_CYCLES=20 -> err[grant_id] pulses 20 clocks after entering WAIT, done stays 0, and arbitration resumes.
REQ-035 Tie: tx_done=1 in the same clock the timeout count is reached -> done pulses, err=0.
REQ-036 Reset mid-frame: rst_n pulled low during WAIT -> all outputs reach their reset values immediately, no done or err pulse, and the next grant goes to requester 0.
REQ-037 Spurious tx_done: tx_done pulsed while in IDLE -> no done pulse and no state change.
